// File: rtl/leaf_credit_sender.sv
// ---------------------------------------------------------------------------
// leaf_credit_sender
//
// Credit-based injection port in front of the internal broadcasting node.
// Flits from a local source are buffered in a small FIFO and launched toward
// the node only while a downstream credit is held, so the node's input buffer
// can never overflow. Credits are returned by one-cycle pulses from the node.
//
// Handshake (local side): a flit is transferred on a rising clk edge where
// src_valid && src_ready are both high. src_ready depends only on registered
// state (FIFO not full); src_valid may depend on src_ready. A pop on the same
// edge never makes room for a push on that edge.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous, active-low reset
//   src_valid         local flit valid
//   src_data          local flit
//   src_ready         FIFO can accept a flit this cycle
//   out_data_valid    registered one-cycle pulse per launched flit
//   out_data          registered flit toward the internal node
//   downstream_credit one credit returned per single-cycle pulse
//   credit_count      credits currently held
//   fifo_count        current FIFO occupancy
//   credit_err        sticky; a credit return arrived while already at maximum
// ---------------------------------------------------------------------------
module leaf_credit_sender #(
    parameter int ROUTER_WIDTH = 32,
    parameter int CREDIT_DEPTH = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    src_valid,
    input  logic [ROUTER_WIDTH-1:0] src_data,
    output logic                    src_ready,
    output logic                    out_data_valid,
    output logic [ROUTER_WIDTH-1:0] out_data,
    input  logic                    downstream_credit,
    output logic [CNT_W-1:0]        credit_count,
    output logic [CNT_W-1:0]        fifo_count,
    output logic                    credit_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [ROUTER_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt_q;
    logic [CNT_W-1:0]        credit_q;
    logic [CNT_W-1:0]        fifo_cnt_d;
    logic [CNT_W-1:0]        credit_d;
    logic                    err_set;
    logic                    push;
    logic                    send;

    // Both decisions use registered state only, so a credit returned on an
    // edge can be spent no earlier than the following edge.
    assign src_ready = (fifo_cnt_q != FIFO_FULL);
    assign push      = src_valid && src_ready;
    assign send      = (fifo_cnt_q != '0) && (credit_q != '0);

    assign credit_count = credit_q;
    assign fifo_count   = fifo_cnt_q;

    always_comb begin
        credit_d = credit_q;
        err_set  = 1'b0;
        case ({send, downstream_credit})
            2'b10: credit_d = credit_q - CNT_ONE;
            2'b01: begin
                // A return at full credit means the node returned more than
                // it was given; clamp and flag it.
                if (credit_q == CREDIT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    credit_d = credit_q + CNT_ONE;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, send})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Storage is not reset: an entry is only read after it has been written,
    // and the pointers/count are cleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= src_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt_q     <= '0;
            credit_q       <= CREDIT_MAX;
            credit_err     <= 1'b0;
            out_data_valid <= 1'b0;
            out_data       <= '0;
        end else begin
            fifo_cnt_q     <= fifo_cnt_d;
            credit_q       <= credit_d;
            out_data_valid <= send;
            if (err_set) begin
                credit_err <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // Head is read from the pre-edge contents, so a simultaneous
            // push into the tail cannot disturb it.
            if (send) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule
